// File: rtl/serial_arith_pkg.sv
// rtl/serial_arith_pkg.sv - shared FSM encoding and width default for serial arithmetic blocks
package serial_arith_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int DEF_W = 8;

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - one-bit combinational full subtractor cell
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bo
);

  // Difference bit and borrow-out of x - y - bin
  always_comb begin
    d  = x ^ y ^ bin;
    bo = (~x & y) | (~(x ^ y) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b, LSB first, one full-subtractor cell
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         bout,
  output logic         zero
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t         state_q;
  logic [W-1:0]   sa_q;
  logic [W-1:0]   sb_q;
  logic [W-1:0]   sr_q;
  logic [W-1:0]   sr_d;
  logic           bor_q;
  logic [CW-1:0]  cnt_q;
  logic           busy_q;
  logic           done_q;
  logic [W-1:0]   diff_q;
  logic           bout_q;
  logic           zero_q;
  logic           cell_d;
  logic           cell_bo;

  full_subtractor u_cell (
    .x   (sa_q[0]),
    .y   (sb_q[0]),
    .bin (bor_q),
    .d   (cell_d),
    .bo  (cell_bo)
  );

  // Result register after this cycle's bit enters at the MSB
  always_comb begin
    sr_d        = sr_q >> 1;
    sr_d[W-1]   = cell_d;
  end

  // Handshake FSM plus serial datapath; outputs are all registered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sr_q    <= '0;
      bor_q   <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            sa_q    <= a;
            sb_q    <= b;
            bor_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          sa_q  <= sa_q >> 1;
          sb_q  <= sb_q >> 1;
          sr_q  <= sr_d;
          bor_q <= cell_bo;
          if (cnt_q == LAST) begin
            // Last bit: publish result, including the bit computed now
            diff_q  <= sr_d;
            bout_q  <= cell_bo;
            zero_q  <= (sr_d == '0);
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed self-checking bench for serial_subtractor (W=8 and W=1)
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       busy8;
  logic       done8;
  logic [7:0] diff8;
  logic       bout8;
  logic       zero8;

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;
  logic       busy1;
  logic       done1;
  logic [0:0] diff1;
  logic       bout1;
  logic       zero1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.W(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .busy  (busy8),
    .done  (done8),
    .diff  (diff8),
    .bout  (bout8),
    .zero  (zero8)
  );

  serial_subtractor #(.W(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .busy  (busy1),
    .done  (done1),
    .diff  (diff1),
    .bout  (bout1),
    .zero  (zero1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One W=8 operation from IDLE; inputs are scrambled right after the start edge
  task automatic op8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                     input logic [7:0] ed, input logic eb, input logic ez);
    int cyc;
    int nbusy;
    a8 = av;
    b8 = bv;
    start8 = 1'b1;
    step();
    start8 = 1'b0;
    a8 = ~av;
    b8 = 8'h5C;
    nbusy = busy8 ? 1 : 0;
    cyc = 0;
    while (done8 !== 1'b1 && cyc < 40) begin
      step();
      cyc++;
      if (busy8) nbusy++;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'd8);
    chk({tag, "_busy_cycles"}, 32'(nbusy), 32'd8);
    chk({tag, "_diff"}, 32'(diff8), 32'(ed));
    chk({tag, "_bout"}, 32'(bout8), 32'(eb));
    chk({tag, "_zero"}, 32'(zero8), 32'(ez));
    step();
    chk({tag, "_done_one_cycle"}, 32'(done8), 32'd0);
  endtask

  // One W=1 operation from IDLE
  task automatic op1(input string tag, input logic av, input logic bv,
                     input logic ed, input logic eb, input logic ez);
    int cyc;
    a1 = av;
    b1 = bv;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    chk({tag, "_busy"}, 32'(busy1), 32'd1);
    cyc = 0;
    while (done1 !== 1'b1 && cyc < 10) begin
      step();
      cyc++;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'd1);
    chk({tag, "_diff"}, 32'(diff1), 32'(ed));
    chk({tag, "_bout"}, 32'(bout1), 32'(eb));
    chk({tag, "_zero"}, 32'(zero1), 32'(ez));
    step();
    chk({tag, "_done_one_cycle"}, 32'(done1), 32'd0);
  endtask

  initial begin
    int t;
    int ndone;

    // Reset state
    rst_n = 1'b0;
    step();
    step();
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_diff", 32'(diff8), 32'd0);
    chk("rst_bout", 32'(bout8), 32'd0);
    chk("rst_zero", 32'(zero8), 32'd0);
    chk("rst_w1_busy", 32'(busy1), 32'd0);
    rst_n = 1'b1;
    step();

    // Basic, underflow, zero, borrow chain
    op8("basic", 8'h5A, 8'h21, 8'h39, 1'b0, 1'b0);
    op8("under", 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0);
    op8("equal", 8'h33, 8'h33, 8'h00, 1'b0, 1'b1);
    op8("chain", 8'h00, 8'hFF, 8'h01, 1'b1, 1'b0);

    // Start held high; operands change after the start edge
    a8 = 8'h05;
    b8 = 8'h03;
    start8 = 1'b1;
    step();
    a8 = 8'hFF;
    b8 = 8'hFF;
    t = 0;
    while (done8 !== 1'b1 && t < 40) begin
      step();
      t++;
    end
    chk("held_latency", 32'(t), 32'd8);
    chk("held_diff", 32'(diff8), 32'h02);
    t = 0;
    do begin
      step();
      t++;
      if (t == 4) begin
        chk("held_busy_mid", 32'(busy8), 32'd1);
        chk("held_diff_kept", 32'(diff8), 32'h02);
      end
    end while (done8 !== 1'b1 && t < 40);
    chk("held_spacing", 32'(t), 32'd10);
    chk("held2_diff", 32'(diff8), 32'h00);
    chk("held2_zero", 32'(zero8), 32'd1);
    start8 = 1'b0;
    step();
    step();
    step();
    chk("held_no_more_busy", 32'(busy8), 32'd0);

    // Nonzero result before the abort so the reset clearing is visible
    op8("pre_rst", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);

    // Reset during the 4th RUN cycle
    a8 = 8'h12;
    b8 = 8'h01;
    start8 = 1'b1;
    step();
    start8 = 1'b0;
    step();
    step();
    step();
    chk("abort_busy_before", 32'(busy8), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("abort_busy", 32'(busy8), 32'd0);
    chk("abort_done", 32'(done8), 32'd0);
    chk("abort_diff", 32'(diff8), 32'd0);
    chk("abort_bout", 32'(bout8), 32'd0);
    chk("abort_zero", 32'(zero8), 32'd0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done8 === 1'b1 || busy8 === 1'b1) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    op8("fresh", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0);

    // W=1 build, all operand combinations
    op1("w1_00", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    op1("w1_10", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    op1("w1_01", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    op1("w1_11", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
